fetch_stage_ctrl: RTL and testbench

- Producer side of the fetch/decode boundary.
- Owns the PC and runs a single-outstanding-request handshake with instruction memory.
- Delivers registered pc_plus_4/instruction/valid to the decode stage.
- Supports hazard stalls (one-entry hold buffer) and branch/jump redirect (flush plus drain of in-flight fetch).

---
 rtl/fetch_stage_ctrl_pkg.sv | 14 +
 rtl/fetch_stage_ctrl_hold_buffer.sv | 33 +++
 rtl/fetch_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_fetch_stage_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared definitions for the fetch stage: PC width, bubble default, FSM states.
package fetch_stage_ctrl_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [PC_W-1:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,  // request outstanding, response is used
        ST_HOLD  = 2'd1,  // decode stalled, fetched word parked in hold buffer
        ST_DRAIN = 2'd2   // request outstanding, response is discarded
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_ctrl_hold_buffer.sv
// One-entry hold buffer parking a fetched word while decode is stalled.
module fetch_stage_ctrl_hold_buffer
    import fetch_stage_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [PC_W-1:0] instr_in,
    input  logic [PC_W-1:0] pc_plus_4_in,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] pc_plus_4,
    output logic            full
);

    // Buffer register: clear wins over load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr     <= '0;
            pc_plus_4 <= '0;
            full      <= 1'b0;
        end else if (clear) begin
            instr     <= '0;
            pc_plus_4 <= '0;
            full      <= 1'b0;
        end else if (load) begin
            instr     <= instr_in;
            pc_plus_4 <= pc_plus_4_in;
            full      <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the PC, runs a single-outstanding imem handshake and
// delivers registered instructions to decode with stall and redirect support.
module fetch_stage_ctrl
    import fetch_stage_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [PC_W-1:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [PC_W-1:0] imem_rdata,
    input  logic            imem_rvalid,
    output logic [PC_W-1:0] pc_plus_4_out,
    output logic [PC_W-1:0] instruction_out,
    output logic            valid_out
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] fetch_addr;
    logic [PC_W-1:0] fetch_addr_p4;
    logic [PC_W-1:0] buf_instr;
    logic [PC_W-1:0] buf_pc_plus_4;
    logic            buf_full;
    logic            buf_load;
    logic            buf_clear;

    assign fetch_addr_p4 = fetch_addr + 32'd4;

    assign buf_load  = (state == ST_WAIT) && imem_rvalid && stall && !redirect;
    assign buf_clear = redirect || ((state == ST_HOLD) && !stall);

    fetch_stage_ctrl_hold_buffer u_hold (
        .clk          (clk),
        .reset        (reset),
        .load         (buf_load),
        .clear        (buf_clear),
        .instr_in     (imem_rdata),
        .pc_plus_4_in (fetch_addr_p4),
        .instr        (buf_instr),
        .pc_plus_4    (buf_pc_plus_4),
        .full         (buf_full)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_WAIT;
        else       state <= state_next;
    end

    // Next-state logic; redirect takes priority over stall and rvalid.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_WAIT: begin
                if (redirect)                 state_next = imem_rvalid ? ST_WAIT : ST_DRAIN;
                else if (imem_rvalid && stall) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (redirect || !stall) state_next = ST_WAIT;
            end
            ST_DRAIN: begin
                // A redirect without the response just retargets pc; the
                // outstanding request still has to be drained.
                if (imem_rvalid) state_next = ST_WAIT;
            end
            default: state_next = ST_WAIT;
        endcase
    end

    // Memory-side outputs; request is suppressed while reset is applied.
    always_comb begin
        imem_req  = (state != ST_HOLD) && !reset;
        imem_addr = fetch_addr;
    end

    // PC, fetch address and decode-side output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc              <= RESET_PC;
            fetch_addr      <= RESET_PC;
            pc_plus_4_out   <= '0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else if (redirect) begin
            pc_plus_4_out   <= '0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
            pc              <= redirect_pc;
            // Keep the old address while a request is still in flight so
            // the response can be drained against a stable imem_addr.
            if ((state == ST_HOLD) || imem_rvalid)
                fetch_addr <= redirect_pc;
        end else begin
            unique case (state)
                ST_WAIT: begin
                    if (imem_rvalid && !stall) begin
                        instruction_out <= imem_rdata;
                        pc_plus_4_out   <= fetch_addr_p4;
                        valid_out       <= 1'b1;
                        pc              <= fetch_addr_p4;
                        fetch_addr      <= fetch_addr_p4;
                    end else if (!imem_rvalid && !stall) begin
                        instruction_out <= NOP_INSTR;
                        valid_out       <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        instruction_out <= buf_instr;
                        pc_plus_4_out   <= buf_pc_plus_4;
                        valid_out       <= buf_full;
                        pc              <= buf_pc_plus_4;
                        fetch_addr      <= buf_pc_plus_4;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) fetch_addr <= pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed, table-driven bench for fetch_stage_ctrl.
module tb_fetch_stage_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic [31:0] pc_plus_4_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    fetch_stage_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .imem_rvalid     (imem_rvalid),
        .pc_plus_4_out   (pc_plus_4_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] rdat;
        logic        req;   // expected before the edge
        logic [31:0] addr;  // expected before the edge
        logic [31:0] p4;    // expected after the edge
        logic [31:0] ins;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic rv,
                                logic [31:0] rdat, logic req, logic [31:0] addr,
                                logic [31:0] p4, logic [31:0] ins, logic v);
        vec_t r;
        r.st = st; r.rd = rd; r.rpc = rpc; r.rv = rv; r.rdat = rdat;
        r.req = req; r.addr = addr; r.p4 = p4; r.ins = ins; r.v = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           st rd rpc           rv rdat          req addr          p4            ins           v
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h8C010004, 1, 32'h0,        32'h4,        32'h8C010004, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h00221820, 1, 32'h4,        32'h8,        32'h00221820, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 32'h11111111, 1, 32'h8,        32'h8,        32'h00221820, 1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'h8,        32'h00221820, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        32'hC,        32'h11111111, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        32'hC,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        32'hC,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'hAAAA0001, 1, 32'hC,        32'h10,       32'hAAAA0001, 1));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'h10,       32'hAAAA0001, 1));
        vecs.push_back(mk(0, 1, 32'h100,      0, 32'h0,        1, 32'h10,       32'h0,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'h0,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'hDEADBEEF, 1, 32'h10,       32'h0,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h22222222, 1, 32'h100,      32'h104,      32'h22222222, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 32'h33333333, 1, 32'h104,      32'h104,      32'h22222222, 1));
        vecs.push_back(mk(1, 1, 32'h200,      0, 32'h0,        0, 32'h104,      32'h0,        NOP,          0));
        vecs.push_back(mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h200,      32'h0,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h44444444, 1, 32'h200,      32'h204,      32'h44444444, 1));
        vecs.push_back(mk(0, 1, 32'hFFFFFFFC, 1, 32'h55555555, 1, 32'h204,      32'h0,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h66666666, 1, 32'hFFFFFFFC, 32'h0,        32'h66666666, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        NOP,          0));
        vecs.push_back(mk(0, 1, 32'h300,      0, 32'h0,        1, 32'h0,        32'h0,        NOP,          0));
        vecs.push_back(mk(0, 1, 32'h400,      0, 32'h0,        1, 32'h0,        32'h0,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h77777777, 1, 32'h0,        32'h0,        NOP,          0));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'h88888888, 1, 32'h400,      32'h404,      32'h88888888, 1));
        vecs.push_back(mk(1, 0, 32'h0,        1, 32'h99999999, 1, 32'h404,      32'h404,      32'h88888888, 1));
        vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 32'h404,      32'h408,      32'h99999999, 1));
        vecs.push_back(mk(0, 0, 32'h0,        1, 32'hABCD0000, 1, 32'h408,      32'h40C,      32'hABCD0000, 1));

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.p4",    pc_plus_4_out,   32'h0);
        check("reset.ins",   instruction_out, NOP);
        check("reset.valid", {31'b0, valid_out}, 32'h0);
        check("reset.req",   {31'b0, imem_req},  32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            stall       = vecs[i].st;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            imem_rvalid = vecs[i].rv;
            imem_rdata  = vecs[i].rdat;
            #1;
            check($sformatf("v%0d.req", i),  {31'b0, imem_req}, {31'b0, vecs[i].req});
            check($sformatf("v%0d.addr", i), imem_addr, vecs[i].addr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.p4", i),    pc_plus_4_out,   vecs[i].p4);
            check($sformatf("v%0d.ins", i),   instruction_out, vecs[i].ins);
            check($sformatf("v%0d.valid", i), {31'b0, valid_out}, {31'b0, vecs[i].v});
        end

        // Asynchronous reset mid-WAIT: outputs clear without a clock edge.
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("areset.p4",    pc_plus_4_out,   32'h0);
        check("areset.ins",   instruction_out, NOP);
        check("areset.valid", {31'b0, valid_out}, 32'h0);
        check("areset.addr",  imem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("restart.req",  {31'b0, imem_req}, 32'h1);
        check("restart.addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'h12345678;
        @(posedge clk);
        #1;
        check("restart.p4",    pc_plus_4_out,   32'h4);
        check("restart.ins",   instruction_out, 32'h12345678);
        check("restart.valid", {31'b0, valid_out}, 32'h1);
        check("restart.next",  imem_addr, 32'h4);
        @(negedge clk);
        imem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
